fifo_rd_prefetch: RTL

Read-side controller of the async FIFO, in the read clock domain, directly downstream of the dual-port memory's registered read port. It owns the read pointer (binary and Gray) and detects empty against the already-synchronized write pointer. It issues memory reads and turns the memory's one-cycle registered read data into a first-word-fall-through valid/ready stream. A two-entry prefetch buffer sustains one word per cycle under continuous `m_ready` and absorbs backpressure without losing data.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_prefetch_buf.sv | 44 ++++
 rtl/fifo_rd_prefetch.sv | 75 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO read and write pointer blocks.
package fifo_pkg;

  localparam int unsigned PTR_MAX = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Callers zero-extend narrower pointers; the zero upper bits decode to zero.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin = gray;
    for (int unsigned i = 1; i < PTR_MAX; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Two-entry register FIFO that holds prefetched memory words ahead of the consumer.
module fifo_prefetch_buf #(
  parameter int unsigned DATASIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [DATASIZE-1:0] din,
  input  logic                pop,
  output logic [1:0]          count,
  output logic [DATASIZE-1:0] head
);

  logic [DATASIZE-1:0] mem [2];
  logic                wr_ptr;
  logic                rd_ptr;

  // Storage and pointers; push and pop may coincide whenever count is nonzero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= 2'(count + 2'd1);
        2'b01:   count <= 2'(count - 2'd1);
        default: count <= count;
      endcase
    end
  end

  assign head = rd_ptr ? mem[1] : mem[0];

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side controller of the async FIFO: read pointer, empty detection and a
// first-word-fall-through stream built on the memory's registered read port.
module fifo_rd_prefetch
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rinc_mem,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic                rempty
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic          inflight;
  logic [1:0]    count;
  logic [1:0]    occ;
  logic [1:0]    occ_after_pop;
  logic          mem_empty;
  logic          pop;

  assign mem_empty = (rptr == rq2_wptr);
  assign pop       = m_valid & m_ready;

  // Buffer slots already claimed, after this cycle's pop frees one; m_ready
  // feeds rinc_mem combinationally so a steady stream never stalls.
  assign occ           = 2'(count + 2'(inflight));
  assign occ_after_pop = 2'(occ - 2'(pop));
  assign rinc_mem      = !mem_empty && (occ_after_pop < 2'd2);

  assign raddr     = rbin[ADDRSIZE-1:0];
  assign rbin_next = PW'(rbin + PW'(1));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rinc_mem;
      if (rinc_mem) begin
        rbin <= rbin_next;
        rptr <= PW'(bin2gray(PTR_MAX'(rbin_next)));
      end
    end
  end

  // Read data arrives one cycle after issue and goes straight into the buffer.
  fifo_prefetch_buf #(
    .DATASIZE(DATASIZE)
  ) u_buf (
    .clk  (rclk),
    .rst_n(rrst_n),
    .push (inflight),
    .din  (rdata_mem),
    .pop  (pop),
    .count(count),
    .head (m_data)
  );

  assign m_valid = (count != 2'd0);
  assign rempty  = mem_empty && !inflight && (count == 2'd0);

endmodule
